// File: rtl/rt_pkg.sv
// Shared definitions for the ray-generation / ray-tracing pipeline.
//   D_BITS    : word width of every coordinate
//   Q_BITS    : fractional bits of the fixed-point format
//   FIXED_ONE : 1.0 in that format
//   vec3_t    : three signed D_BITS lanes, [0]=x [1]=y [2]=z
//   ray_t     : origin + direction pair
//   state_e   : camera_ray_gen frame sequencer states
//   vec3_add  : lane-wise wrap-around add
package rt_pkg;

  localparam int D_BITS = 32;
  localparam int Q_BITS = 16;
  localparam logic [D_BITS-1:0] FIXED_ONE = 32'd1 << Q_BITS;

  typedef logic signed [2:0][D_BITS-1:0] vec3_t;

  typedef struct packed {
    vec3_t org;
    vec3_t dir;
  } ray_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Two's-complement add per lane; overflow wraps, no saturation.
  function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
    vec3_t r;
    for (int l = 0; l < 3; l++) begin
      r[l] = a[l] + b[l];
    end
    return r;
  endfunction

endpackage

// File: rtl/vec3_acc.sv
// Three-lane accumulator register used for the running ray direction and
// the start-of-row direction.
//   clock, reset : clock and synchronous active-high reset (clears to 0)
//   load_i       : take load_val_i (has priority over add_i)
//   add_i        : accumulate step_i
//   load_val_i   : value loaded on load_i
//   step_i       : increment applied on add_i
//   val_o        : current register contents
module vec3_acc
  import rt_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  load_i,
  input  logic  add_i,
  input  vec3_t load_val_i,
  input  vec3_t step_i,
  output vec3_t val_o
);

  vec3_t val_q;
  vec3_t val_d;

  // Next value: load, add-step or hold.
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (add_i) begin
      val_d = vec3_add(val_q, step_i);
    end else begin
      val_d = val_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clock) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/camera_ray_gen.sv
// Primary-ray generator: emits one ray per pixel of an IMG_W x IMG_H image in
// raster order into the ray FIFO of ray_tracer_top. Directions are built by
// incremental addition (corner + x*du + y*dv) with no multipliers.
//   clock, reset   : clock, synchronous active-high reset
//   start          : one-cycle pulse, begins a frame when idle
//   cam_origin     : camera position (every ray's origin)
//   cam_corner     : direction of pixel (0,0)
//   cam_du, cam_dv : direction step per +1 x / +1 y
//   out_full       : downstream FIFO full
//   out_wr_en      : FIFO write strobe (ray accepted on a posedge with it high)
//   ray_out        : [0..2] origin xyz, [3..5] direction xyz
//   pixel_x/y      : pixel index of ray_out
//   busy           : high while rays are being produced
//   done           : one-cycle pulse after the last ray is written
module camera_ray_gen
  import rt_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  vec3_t                  cam_origin,
  input  vec3_t                  cam_corner,
  input  vec3_t                  cam_du,
  input  vec3_t                  cam_dv,
  input  logic                   out_full,
  output logic                   out_wr_en,
  output logic [5:0][D_BITS-1:0] ray_out,
  output logic [XW-1:0]          pixel_x,
  output logic [YW-1:0]          pixel_y,
  output logic                   busy,
  output logic                   done
);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  vec3_t         org_q, org_d;
  vec3_t         du_q, du_d;
  vec3_t         dv_q, dv_d;

  logic  dir_load_s, dir_add_s, row_load_s, row_add_s;
  logic  last_x_s, last_y_s;
  vec3_t dir_load_val_s, dir_s, row_s, row_next_s;

  assign last_x_s   = (x_q == XW'(IMG_W - 1));
  assign last_y_s   = (y_q == YW'(IMG_H - 1));
  assign row_next_s = vec3_add(row_s, dv_q);

  // Running direction of the ray currently presented on ray_out.
  vec3_acc u_dir (
    .clock      (clock),
    .reset      (reset),
    .load_i     (dir_load_s),
    .add_i      (dir_add_s),
    .load_val_i (dir_load_val_s),
    .step_i     (du_q),
    .val_o      (dir_s)
  );

  // Direction of pixel (0,y) for the current row.
  vec3_acc u_row (
    .clock      (clock),
    .reset      (reset),
    .load_i     (row_load_s),
    .add_i      (row_add_s),
    .load_val_i (cam_corner),
    .step_i     (dv_q),
    .val_o      (row_s)
  );

  // Frame sequencer: next state, counters and strobes.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    org_d          = org_q;
    du_d           = du_q;
    dv_d           = dv_q;
    dir_load_s     = 1'b0;
    dir_add_s      = 1'b0;
    dir_load_val_s = cam_corner;
    row_load_s     = 1'b0;
    row_add_s      = 1'b0;
    out_wr_en      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          org_d      = cam_origin;
          du_d       = cam_du;
          dv_d       = cam_dv;
          x_d        = '0;
          y_d        = '0;
          dir_load_s = 1'b1;
          row_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        out_wr_en = !out_full;
        if (out_wr_en) begin
          if (!last_x_s) begin
            x_d       = x_q + XW'(1);
            dir_add_s = 1'b1;
          end else if (!last_y_s) begin
            // Row wrap: the new direction is the next row base, formed from the
            // old base so both accumulators update on the same edge.
            x_d            = '0;
            y_d            = y_q + YW'(1);
            row_add_s      = 1'b1;
            dir_load_s     = 1'b1;
            dir_load_val_s = row_next_s;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and latched camera parameters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      org_q   <= '0;
      du_q    <= '0;
      dv_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      org_q   <= org_d;
      du_q    <= du_d;
      dv_q    <= dv_d;
    end
  end

  assign ray_out = {dir_s, org_q};
  assign pixel_x = x_q;
  assign pixel_y = y_q;

endmodule

// File: tb/tb_camera_ray_gen.sv
// Self-checking bench for camera_ray_gen: three instances (4x2, 32x32, 2x1)
// share clock, reset and camera inputs. Expected rays are computed with
// multiplies from the camera vectors and queued when a frame is started.
module tb_camera_ray_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0][31:0] cam_origin, cam_corner, cam_du, cam_dv;

  logic             start4, full4, wr4, busy4, done4;
  logic [5:0][31:0] ray4;
  logic [1:0]       px4;
  logic [0:0]       py4;

  logic             start32, full32, wr32, busy32, done32;
  logic [5:0][31:0] ray32;
  logic [4:0]       px32;
  logic [4:0]       py32;

  logic             start21, full21, wr21, busy21, done21;
  logic [5:0][31:0] ray21;
  logic [0:0]       px21;
  logic [0:0]       py21;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int               x;
    int               y;
    logic [5:0][31:0] ray;
  } exp_t;
  exp_t q[$];

  camera_ray_gen #(.IMG_W(4), .IMG_H(2)) dut4 (
    .clock(clock), .reset(reset), .start(start4),
    .cam_origin(cam_origin), .cam_corner(cam_corner), .cam_du(cam_du), .cam_dv(cam_dv),
    .out_full(full4), .out_wr_en(wr4), .ray_out(ray4),
    .pixel_x(px4), .pixel_y(py4), .busy(busy4), .done(done4)
  );

  camera_ray_gen #(.IMG_W(32), .IMG_H(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32),
    .cam_origin(cam_origin), .cam_corner(cam_corner), .cam_du(cam_du), .cam_dv(cam_dv),
    .out_full(full32), .out_wr_en(wr32), .ray_out(ray32),
    .pixel_x(px32), .pixel_y(py32), .busy(busy32), .done(done32)
  );

  camera_ray_gen #(.IMG_W(2), .IMG_H(1)) dut21 (
    .clock(clock), .reset(reset), .start(start21),
    .cam_origin(cam_origin), .cam_corner(cam_corner), .cam_du(cam_du), .cam_dv(cam_dv),
    .out_full(full21), .out_wr_en(wr21), .ray_out(ray21),
    .pixel_x(px21), .pixel_y(py21), .busy(busy21), .done(done21)
  );

  // Queue the expected rays of a w x h frame from the current camera inputs.
  task automatic push_frame(input int w, input int h);
    exp_t e;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        e.x = x;
        e.y = y;
        for (int l = 0; l < 3; l++) begin
          e.ray[l]   = cam_origin[l];
          e.ray[l+3] = cam_corner[l] + 32'(x) * cam_du[l] + 32'(y) * cam_dv[l];
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic set_cam_basic();
    cam_origin = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    cam_corner = {32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000};
    cam_du     = {32'h0000_0000, 32'h0000_0000, 32'h0000_4000};
    cam_dv     = {32'h0000_0000, 32'h0000_8000, 32'h0000_0000};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({wr4, busy4, done4, px4, py4} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl4: got wr=%0b busy=%0b done=%0b px=%0d py=%0d want all 0", wr4, busy4, done4, px4, py4);
    end
    total++;
    if (ray4 !== '0) begin
      bad++;
      $display("FAIL reset_ray4: got %h want 0", ray4);
    end
    total++;
    if ({wr32, busy32, done32, px32, py32, wr21, busy21, done21} !== 16'b0) begin
      bad++;
      $display("FAIL reset_ctl_other: got wr32=%0b busy32=%0b wr21=%0b busy21=%0b want 0", wr32, busy32, wr21, busy21);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int writes = 0, dones = 0, first_c = 0, last_c = 0, done_c = 0;
    logic [5:0][31:0] ray5 = '0;
    exp_t e;
    set_cam_basic();
    q.delete();
    push_frame(4, 2);
    @(negedge clock); start4 = 1'b1; full4 = 1'b0;
    @(negedge clock); start4 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      if (c == 1) begin
        total++;
        if (busy4 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b want 1", busy4); end
      end
      if (wr4) begin
        writes++;
        if (writes == 1) first_c = c;
        last_c = c;
        if (writes == 6) ray5 = ray4;
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL basic_extra: unexpected write px=%0d py=%0d", px4, py4);
        end else begin
          e = q.pop_front();
          if ({32'(px4), 32'(py4), ray4} !== {e.x, e.y, e.ray}) begin
            bad++;
            $display("FAIL basic_ray: got (%0d,%0d) %h want (%0d,%0d) %h", px4, py4, ray4, e.x, e.y, e.ray);
          end
        end
      end
      if (done4) begin dones++; done_c = c; end
    end
    total++;
    if (writes != 8 || first_c != 1 || last_c != 8) begin
      bad++; $display("FAIL basic_count: got writes=%0d first=%0d last=%0d want 8,1,8", writes, first_c, last_c);
    end
    total++;
    if (dones != 1 || done_c != 9) begin
      bad++; $display("FAIL basic_done: got dones=%0d at cycle %0d want 1 at 9", dones, done_c);
    end
    total++;
    if (ray5[5:3] !== {32'hFFFF_0000, 32'h0000_8000, 32'h0000_4000}) begin
      bad++; $display("FAIL basic_write5: got %h want ffff0000_00008000_00004000", ray5[5:3]);
    end
  endtask

  task automatic test_backpressure();
    int writes = 0, dones = 0;
    logic prev_stall = 1'b0;
    logic [5:0][31:0] stall_ray = '0;
    exp_t e;
    set_cam_basic();
    q.delete();
    push_frame(4, 2);
    @(negedge clock); start4 = 1'b1; full4 = 1'b0;
    @(negedge clock); start4 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clock);
      full4 = (c % 2 == 0);
      #1;
      if (prev_stall) begin
        total++;
        if (ray4 !== stall_ray) begin
          bad++; $display("FAIL bp_hold: got %h want %h", ray4, stall_ray);
        end
      end
      prev_stall = full4 && busy4;
      stall_ray  = ray4;
      if (full4) begin
        total++;
        if (wr4 !== 1'b0) begin bad++; $display("FAIL bp_wr_when_full: got %0b want 0", wr4); end
      end
      if (wr4) begin
        writes++;
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra: unexpected write px=%0d py=%0d", px4, py4);
        end else begin
          e = q.pop_front();
          if ({32'(px4), 32'(py4), ray4} !== {e.x, e.y, e.ray}) begin
            bad++;
            $display("FAIL bp_ray: got (%0d,%0d) %h want (%0d,%0d) %h", px4, py4, ray4, e.x, e.y, e.ray);
          end
        end
      end
      if (done4) dones++;
    end
    full4 = 1'b0;
    total++;
    if (writes != 8 || dones != 1) begin
      bad++; $display("FAIL bp_count: got writes=%0d dones=%0d want 8,1", writes, dones);
    end
  endtask

  task automatic test_back_to_back();
    int writes = 0, dones = 0, busy_after = 0;
    exp_t e;
    set_cam_basic();
    q.delete();
    push_frame(4, 2);
    @(negedge clock); start4 = 1'b1; full4 = 1'b0;
    @(negedge clock); start4 = 1'b0;
    // Camera inputs are don't-care once the frame has started.
    cam_du = '1; cam_dv = '1; cam_origin = '0; cam_corner = '1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clock);
      start4 = (c == 3) || (c == 9);
      #1;
      if (c == 9) begin
        total++;
        if (done4 !== 1'b1) begin bad++; $display("FAIL b2b_done_cycle: got %0b want 1", done4); end
      end
      if (c >= 10 && busy4) busy_after++;
      if (wr4) begin
        writes++;
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: unexpected write px=%0d py=%0d", px4, py4);
        end else begin
          e = q.pop_front();
          if ({32'(px4), 32'(py4), ray4} !== {e.x, e.y, e.ray}) begin
            bad++;
            $display("FAIL b2b_ray: got (%0d,%0d) %h want (%0d,%0d) %h", px4, py4, ray4, e.x, e.y, e.ray);
          end
        end
      end
      if (done4) dones++;
    end
    start4 = 1'b0;
    total++;
    if (writes != 8 || dones != 1 || busy_after != 0) begin
      bad++; $display("FAIL b2b_count: got writes=%0d dones=%0d busy_after=%0d want 8,1,0", writes, dones, busy_after);
    end
  endtask

  task automatic set_cam_big();
    cam_origin = {32'h0000_1234, 32'hFFFE_0000, 32'h0005_8000};
    cam_corner = {32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000};
    cam_du     = {32'h0000_0010, 32'h0000_0000, 32'h0000_0800};
    cam_dv     = {32'h0000_0000, 32'hFFFF_F800, 32'h0000_0003};
  endtask

  task automatic test_full_frame();
    int writes = 0, dones = 0;
    logic [2:0][31:0] want_last, got_last;
    exp_t e;
    set_cam_big();
    for (int l = 0; l < 3; l++) want_last[l] = cam_corner[l] + 32'd31 * cam_du[l] + 32'd31 * cam_dv[l];
    got_last = '0;
    q.delete();
    push_frame(32, 32);
    @(negedge clock); start32 = 1'b1; full32 = 1'b0;
    @(negedge clock); start32 = 1'b0;
    for (int c = 1; c <= 2200; c++) begin
      if (c > 1) @(negedge clock);
      full32 = ($urandom_range(0, 3) == 0);
      #1;
      if (wr32) begin
        writes++;
        if (px32 == 5'd31 && py32 == 5'd31) got_last = ray32[5:3];
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL full_extra: unexpected write px=%0d py=%0d", px32, py32);
        end else begin
          e = q.pop_front();
          if ({32'(px32), 32'(py32), ray32} !== {e.x, e.y, e.ray}) begin
            bad++;
            $display("FAIL full_ray: got (%0d,%0d) %h want (%0d,%0d) %h", px32, py32, ray32, e.x, e.y, e.ray);
          end
        end
      end
      if (done32) dones++;
    end
    full32 = 1'b0;
    total++;
    if (writes != 1024 || dones != 1) begin
      bad++; $display("FAIL full_count: got writes=%0d dones=%0d want 1024,1", writes, dones);
    end
    total++;
    if (got_last !== want_last) begin
      bad++; $display("FAIL full_pix31_31: got %h want %h", got_last, want_last);
    end
  endtask

  task automatic test_reset_mid();
    int writes = 0, dones = 0, late = 0;
    exp_t e;
    set_cam_big();
    q.delete();
    push_frame(32, 32);
    @(negedge clock); start32 = 1'b1; full32 = 1'b0;
    @(negedge clock); start32 = 1'b0;
    for (int c = 1; c <= 300 && writes < 100; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      if (wr32) writes++;
    end
    total++;
    if (writes != 100) begin bad++; $display("FAIL rst_mid_reach: got writes=%0d want 100", writes); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    #1;
    total++;
    if ({wr32, busy32, done32, px32, py32} !== 13'b0 || ray32 !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got wr=%0b busy=%0b done=%0b px=%0d py=%0d ray=%h want all 0",
               wr32, busy32, done32, px32, py32, ray32);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      if (wr32 || done32 || busy32) late++;
    end
    total++;
    if (late != 0) begin bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", late); end
    q.delete();
    push_frame(32, 32);
    writes = 0;
    @(negedge clock); start32 = 1'b1;
    @(negedge clock); start32 = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      if (wr32) begin
        writes++;
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rst_mid_extra: unexpected write px=%0d py=%0d", px32, py32);
        end else begin
          e = q.pop_front();
          if ({32'(px32), 32'(py32), ray32} !== {e.x, e.y, e.ray}) begin
            bad++;
            $display("FAIL rst_mid_ray: got (%0d,%0d) %h want (%0d,%0d) %h", px32, py32, ray32, e.x, e.y, e.ray);
          end
        end
      end
      if (done32) dones++;
    end
    total++;
    if (writes != 1024 || dones != 1) begin
      bad++; $display("FAIL rst_mid_refill: got writes=%0d dones=%0d want 1024,1", writes, dones);
    end
  endtask

  task automatic test_wrap();
    int writes = 0, dones = 0, done_c = 0;
    logic [31:0] dir2x = '0;
    exp_t e;
    cam_origin = {32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
    cam_corner = {32'h0000_1000, 32'hFFFF_0000, 32'h7FFF_0000};
    cam_du     = {32'h0000_0000, 32'h0000_0100, 32'h0001_0000};
    cam_dv     = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    q.delete();
    push_frame(2, 1);
    @(negedge clock); start21 = 1'b1; full21 = 1'b0;
    @(negedge clock); start21 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      if (c == 1) begin
        total++;
        if (busy21 !== 1'b1) begin bad++; $display("FAIL wrap_busy: got %0b want 1", busy21); end
      end
      if (wr21) begin
        writes++;
        if (writes == 2) dir2x = ray21[3];
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL wrap_extra: unexpected write px=%0d py=%0d", px21, py21);
        end else begin
          e = q.pop_front();
          if ({32'(px21), 32'(py21), ray21} !== {e.x, e.y, e.ray}) begin
            bad++;
            $display("FAIL wrap_ray: got (%0d,%0d) %h want (%0d,%0d) %h", px21, py21, ray21, e.x, e.y, e.ray);
          end
        end
      end
      if (done21) begin dones++; done_c = c; end
    end
    total++;
    if (dir2x !== 32'h8000_0000) begin bad++; $display("FAIL wrap_dirx: got %h want 80000000", dir2x); end
    total++;
    if (writes != 2 || dones != 1 || done_c != 3) begin
      bad++; $display("FAIL wrap_count: got writes=%0d dones=%0d done_c=%0d want 2,1,3", writes, dones, done_c);
    end
  endtask

  initial begin
    start4 = 1'b0;  full4 = 1'b0;
    start32 = 1'b0; full32 = 1'b0;
    start21 = 1'b0; full21 = 1'b0;
    cam_origin = '0; cam_corner = '0; cam_du = '0; cam_dv = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_full_frame();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
